// File: rtl/ap_pkg.sv
// Shared interrupt-controller definitions: FSM encodings, vector stride, width helper.
package ap_pkg;

    localparam int unsigned VEC_STRIDE = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BND  = 3'd1,
        ST_PUSH      = 3'd2,
        ST_JUMP      = 3'd3,
        ST_WAIT_LOAD = 3'd4,
        ST_RET_POP   = 3'd5,
        ST_RET_RDY   = 3'd6,
        ST_RET_END   = 3'd7
    } int_state_e;

    // Index width that stays legal (>= 1 bit) for single-entry structures.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_ret_stack.sv
// Return stack holding {return address, saved priority level} per nesting level.
module int_ret_stack
    import ap_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned LVL_W       = 3,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned DEP_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [LVL_W-1:0]  i_wr_lvl,
    output logic [ADDR_W-1:0] o_top_addr,
    output logic [LVL_W-1:0]  o_top_lvl,
    output logic [DEP_W-1:0]  o_depth
);

    localparam int unsigned PTR_W = clog2_min1(STACK_DEPTH);
    localparam int unsigned ENT_W = ADDR_W + LVL_W;

    logic [ENT_W-1:0] r_mem [STACK_DEPTH];
    logic [DEP_W-1:0] r_depth;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_full;
    logic             w_empty;

    assign w_full   = (r_depth == DEP_W'(STACK_DEPTH));
    assign w_empty  = (r_depth == '0);
    assign w_wr_ptr = PTR_W'(r_depth);
    assign w_rd_ptr = PTR_W'(r_depth - DEP_W'(1));

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_push && !w_full) begin
            r_mem[w_wr_ptr] <= {i_wr_addr, i_wr_lvl};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_depth <= '0;
        end else if (i_push && !w_full) begin
            r_depth <= r_depth + DEP_W'(1);
        end else if (i_pop && !w_empty) begin
            r_depth <= r_depth - DEP_W'(1);
        end
    end

    assign {o_top_addr, o_top_lvl} = r_mem[w_rd_ptr];
    assign o_depth                 = r_depth;

endmodule

// File: rtl/int_ctrl.sv
// Nested priority interrupt controller: accepts requests at instruction boundaries,
// jumps to the vector table and sequences return-from-interrupt handshakes.
module int_ctrl
    import ap_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_MEM = 16,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned STACK_DEPTH    = 4,
    localparam int unsigned DEP_W         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        i_int_req,
    input  logic [DDR_ADDR_WIDTH-1:0] i_int_vec_base,
    input  logic [ADDR_WIDTH_MEM-1:0] i_addr_cur_ins,
    input  logic                      i_ins_boundary,
    input  logic                      i_ret_req,
    input  logic                      i_ins_inp_valid,
    output logic                      o_int,
    output logic [DDR_ADDR_WIDTH-1:0] o_jmp_addr_pc,
    output logic [NUM_SRC-1:0]        o_int_ack,
    output logic                      o_ret_valid,
    output logic [ADDR_WIDTH_MEM-1:0] o_ret_addr_pc,
    output logic                      o_ret_addr_pc_rdy,
    output logic [DEP_W-1:0]          o_depth,
    output logic                      o_stack_err
);

    localparam int unsigned LVL_W = $clog2(NUM_SRC + 1);
    localparam int unsigned IDX_W = clog2_min1(NUM_SRC);

    int_state_e                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [ADDR_WIDTH_MEM-1:0] r_addr;
    logic [LVL_W-1:0]          r_cur_level;

    logic                      w_acc_valid;
    logic [IDX_W-1:0]          w_acc_idx;
    logic                      w_push;
    logic                      w_pop;
    logic [ADDR_WIDTH_MEM-1:0] w_top_addr;
    logic [LVL_W-1:0]          w_top_lvl;
    logic [DEP_W-1:0]          w_depth;

    // Lowest-index request that outranks the running level; blocked when the stack is full.
    always_comb begin
        w_acc_valid = 1'b0;
        w_acc_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_int_req[i] && (LVL_W'(i) < r_cur_level)) begin
                w_acc_valid = 1'b1;
                w_acc_idx   = IDX_W'(i);
            end
        end
        if (w_depth == DEP_W'(STACK_DEPTH)) begin
            w_acc_valid = 1'b0;
        end
    end

    assign w_push = (r_state == ST_PUSH);
    assign w_pop  = (r_state == ST_RET_POP) && (w_depth != '0);

    int_ret_stack #(
        .ADDR_W      (ADDR_WIDTH_MEM),
        .LVL_W       (LVL_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_wr_addr  (r_addr),
        .i_wr_lvl   (r_cur_level),
        .o_top_addr (w_top_addr),
        .o_top_lvl  (w_top_lvl),
        .o_depth    (w_depth)
    );

    assign o_depth = w_depth;

    // Outputs are set on the transition into the state in which they must be seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= ST_IDLE;
            r_idx             <= '0;
            r_addr            <= '0;
            r_cur_level       <= LVL_W'(NUM_SRC);
            o_int             <= 1'b0;
            o_int_ack         <= '0;
            o_jmp_addr_pc     <= '0;
            o_ret_valid       <= 1'b0;
            o_ret_addr_pc_rdy <= 1'b0;
            o_ret_addr_pc     <= '0;
            o_stack_err       <= 1'b0;
        end else begin
            o_int     <= 1'b0;
            o_int_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (i_ret_req) begin
                        o_ret_valid <= (w_depth != '0);
                        r_state     <= ST_RET_POP;
                    end else if (w_acc_valid) begin
                        r_idx   <= w_acc_idx;
                        r_state <= ST_WAIT_BND;
                    end
                end
                ST_WAIT_BND: begin
                    if (i_ins_boundary) begin
                        r_addr  <= i_addr_cur_ins;
                        r_state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    r_cur_level   <= LVL_W'(r_idx);
                    o_int         <= 1'b1;
                    o_int_ack     <= NUM_SRC'(1) << r_idx;
                    o_jmp_addr_pc <= i_int_vec_base + DDR_ADDR_WIDTH'(VEC_STRIDE * 32'(r_idx));
                    r_state       <= ST_JUMP;
                end
                ST_JUMP: begin
                    r_state <= ST_WAIT_LOAD;
                end
                ST_WAIT_LOAD: begin
                    if (i_ins_inp_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RET_POP: begin
                    if (w_depth == '0) begin
                        o_stack_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        o_ret_addr_pc     <= w_top_addr;
                        r_cur_level       <= w_top_lvl;
                        o_ret_addr_pc_rdy <= 1'b1;
                        r_state           <= ST_RET_RDY;
                    end
                end
                ST_RET_RDY: begin
                    o_ret_valid       <= 1'b0;
                    o_ret_addr_pc_rdy <= 1'b0;
                    r_state           <= ST_RET_END;
                end
                ST_RET_END: begin
                    if (i_ins_inp_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: entry, nesting, returns, underflow, full stack, reset.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  int_req;
    logic [27:0] int_vec_base;
    logic [15:0] addr_cur_ins;
    logic        ins_boundary;
    logic        ret_req;
    logic        ins_inp_valid;
    logic        o_int;
    logic [27:0] jmp_addr_pc;
    logic [3:0]  int_ack;
    logic        ret_valid;
    logic [15:0] ret_addr_pc;
    logic        ret_addr_pc_rdy;
    logic [2:0]  depth;
    logic        stack_err;

    int n_checks;
    int n_errors;

    int_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .i_int_req         (int_req),
        .i_int_vec_base    (int_vec_base),
        .i_addr_cur_ins    (addr_cur_ins),
        .i_ins_boundary    (ins_boundary),
        .i_ret_req         (ret_req),
        .i_ins_inp_valid   (ins_inp_valid),
        .o_int             (o_int),
        .o_jmp_addr_pc     (jmp_addr_pc),
        .o_int_ack         (int_ack),
        .o_ret_valid       (ret_valid),
        .o_ret_addr_pc     (ret_addr_pc),
        .o_ret_addr_pc_rdy (ret_addr_pc_rdy),
        .o_depth           (depth),
        .o_stack_err       (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Full entry sequence; request is dropped once the pulse has been checked.
    task automatic do_int(input string tag, input logic [3:0] req, input logic [15:0] addr,
                          input logic [27:0] exp_jmp, input logic [3:0] exp_ack,
                          input logic [2:0] exp_depth);
        int_req      = req;
        addr_cur_ins = addr;
        tick();
        ins_boundary = 1'b1;
        tick();
        ins_boundary = 1'b0;
        tick();
        check_eq({tag, "_int"},   32'(o_int), 32'd1);
        check_eq({tag, "_jmp"},   32'(jmp_addr_pc), 32'(exp_jmp));
        check_eq({tag, "_ack"},   32'(int_ack), 32'(exp_ack));
        check_eq({tag, "_depth"}, 32'(depth), 32'(exp_depth));
        int_req = '0;
        tick();
        check_eq({tag, "_int_low"}, 32'(o_int), 32'd0);
        check_eq({tag, "_jmp_hold"}, 32'(jmp_addr_pc), 32'(exp_jmp));
        ins_inp_valid = 1'b1;
        tick();
        ins_inp_valid = 1'b0;
    endtask

    task automatic do_ret(input string tag, input logic [15:0] exp_addr, input logic [2:0] exp_depth);
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check_eq({tag, "_valid1"}, 32'(ret_valid), 32'd1);
        check_eq({tag, "_rdy1"},   32'(ret_addr_pc_rdy), 32'd0);
        tick();
        check_eq({tag, "_valid2"}, 32'(ret_valid), 32'd1);
        check_eq({tag, "_rdy2"},   32'(ret_addr_pc_rdy), 32'd1);
        check_eq({tag, "_addr"},   32'(ret_addr_pc), 32'(exp_addr));
        check_eq({tag, "_depth"},  32'(depth), 32'(exp_depth));
        tick();
        check_eq({tag, "_valid3"}, 32'(ret_valid), 32'd0);
        check_eq({tag, "_rdy3"},   32'(ret_addr_pc_rdy), 32'd0);
        ins_inp_valid = 1'b1;
        tick();
        ins_inp_valid = 1'b0;
    endtask

    // Hold a request with boundary pulses and count interrupt pulses seen.
    task automatic expect_no_accept(input string tag, input logic [3:0] req, input logic [2:0] exp_depth);
        int pulses;
        pulses  = 0;
        int_req = req;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_int) pulses++;
            ins_boundary = (c % 2 == 0);
        end
        ins_boundary = 1'b0;
        int_req      = '0;
        tick();
        check_eq({tag, "_pulses"}, 32'(pulses), 32'd0);
        check_eq({tag, "_depth"},  32'(depth), 32'(exp_depth));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_int"},       32'(o_int), 32'd0);
        check_eq({tag, "_jmp"},       32'(jmp_addr_pc), 32'd0);
        check_eq({tag, "_ack"},       32'(int_ack), 32'd0);
        check_eq({tag, "_ret_valid"}, 32'(ret_valid), 32'd0);
        check_eq({tag, "_ret_addr"},  32'(ret_addr_pc), 32'd0);
        check_eq({tag, "_ret_rdy"},   32'(ret_addr_pc_rdy), 32'd0);
        check_eq({tag, "_depth"},     32'(depth), 32'd0);
        check_eq({tag, "_stack_err"}, 32'(stack_err), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        int_req       = '0;
        int_vec_base  = 28'h1000;
        addr_cur_ins  = '0;
        ins_boundary  = 1'b0;
        ret_req       = 1'b0;
        ins_inp_valid = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Single entry then nested higher-priority entry; lower priority blocked.
        do_int("single", 4'b0100, 16'h0025, 28'h1010, 4'b0100, 3'd1);
        do_int("nested", 4'b0001, 16'h0040, 28'h1000, 4'b0001, 3'd2);
        expect_no_accept("low_blocked", 4'b1000, 3'd2);

        // Unwind both levels; innermost return address comes back first.
        do_ret("ret_inner", 16'h0040, 3'd1);
        do_ret("ret_outer", 16'h0025, 3'd0);

        // Return with empty stack raises the sticky error and no ret_valid.
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        check_eq("underflow_valid1", 32'(ret_valid), 32'd0);
        tick();
        check_eq("underflow_valid2", 32'(ret_valid), 32'd0);
        check_eq("underflow_err",    32'(stack_err), 32'd1);
        check_eq("underflow_depth",  32'(depth), 32'd0);

        // Fill the stack from lowest to highest priority.
        do_int("fill3", 4'b1000, 16'h0100, 28'h1018, 4'b1000, 3'd1);
        do_int("fill2", 4'b0100, 16'h0200, 28'h1010, 4'b0100, 3'd2);
        do_int("fill1", 4'b0010, 16'h0300, 28'h1008, 4'b0010, 3'd3);
        do_int("fill0", 4'b0001, 16'h0400, 28'h1000, 4'b0001, 3'd4);
        expect_no_accept("full", 4'b0001, 3'd4);
        do_ret("ret_full", 16'h0400, 3'd3);

        // Level is back to 1, so src0 is acceptable, but the return must win.
        int_req = 4'b0001;
        do_ret("ret_prio", 16'h0300, 3'd2);
        int_req = '0;
        tick();
        check_eq("ret_prio_no_int", 32'(o_int), 32'd0);

        // Reset while waiting for the boundary abandons the sequence.
        int_req = 4'b0001;
        tick();
        rst = 1'b0;
        #1;
        check_eq("midrst_int",   32'(o_int), 32'd0);
        check_eq("midrst_depth", 32'(depth), 32'd0);
        check_eq("midrst_err",   32'(stack_err), 32'd0);
        check_eq("midrst_jmp",   32'(jmp_addr_pc), 32'd0);
        int_req = '0;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b1;
        tick();
        do_int("post_rst", 4'b0100, 16'h0025, 28'h1010, 4'b0100, 3'd1);
        do_ret("post_rst_ret", 16'h0025, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
